// File: rtl/adc_sum_sq_integ_ctrl.sv
// Sum-of-squares integration window controller for one ADC power channel.
// Windows align to sync_in, then free-run; each completed total is held for the CPU register.
module adc_sum_sq_integ_ctrl #(
  parameter int SQ_W  = 16,
  parameter int ACC_W = 32,
  parameter int LEN_W = 24
) (
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic             sync_in,
  input  logic             sample_valid,
  input  logic [SQ_W-1:0]  sq_in,
  input  logic             cfg_enable,
  input  logic             cfg_one_shot,
  input  logic [LEN_W-1:0] cfg_acc_len,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  output logic [15:0]      win_count,
  output logic             sat_flag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    ACCUM     = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_en;
  logic               r_en_d;
  logic [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  logic [ACC_W-1:0]   r_sum_out;
  logic               r_sum_valid;
  logic [15:0]        r_win_count;
  logic               r_sat;
  logic               r_busy;

  logic               w_arm;
  logic [ACC_W-1:0]   w_sq_ext;
  logic [ACC_W:0]     w_sum_wide;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_sat;
  logic [LEN_W-1:0]   w_cnt_inc;
  logic [LEN_W-1:0]   w_len_cfg;
  logic               w_arm_clear;
  logic               w_start;
  logic               w_accept;
  logic               w_dump;

  // Arm is a rising edge of the registered enable, so software can hold the level.
  assign w_arm      = r_en & ~r_en_d;

  // One extra bit of headroom exposes the carry that drives saturation.
  assign w_sq_ext   = ACC_W'(sq_in);
  assign w_sum_wide = {1'b0, r_acc} + {1'b0, w_sq_ext};
  assign w_carry    = w_sum_wide[ACC_W];
  assign w_acc_sat  = w_carry ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];

  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_len_cfg  = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_clear = 1'b0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_dump      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arm) begin
          w_arm_clear = 1'b1;
          w_state_nxt = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (!r_en) begin
          w_state_nxt = IDLE;
        end else if (sync_in) begin
          w_start     = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (sample_valid) begin
          w_accept = 1'b1;
          w_dump   = (w_cnt_inc == r_len);
        end
        // A final sample coinciding with an abort still dumps before leaving.
        if (!r_en || (w_dump && cfg_one_shot)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state <= IDLE;
      r_en    <= 1'b0;
      r_en_d  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= cfg_enable;
      r_en_d  <= r_en;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Window datapath: a dump clears and re-latches in the same edge so the next sample starts a new window.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (w_start || w_dump) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= w_len_cfg;
    end else if (w_accept) begin
      r_acc <= w_acc_sat;
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_sum_out   <= '0;
      r_sum_valid <= 1'b0;
      r_win_count <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_sum_valid <= w_dump;
      if (w_dump) begin
        r_sum_out <= w_acc_sat;
      end
      if (w_arm_clear) begin
        r_win_count <= '0;
      end else if (w_dump) begin
        r_win_count <= r_win_count + 16'd1;
      end
      if (w_arm_clear) begin
        r_sat <= 1'b0;
      end else if (w_accept && w_carry) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign sum_out   = r_sum_out;
  assign sum_valid = r_sum_valid;
  assign win_count = r_win_count;
  assign sat_flag  = r_sat;
  assign busy      = r_busy;

endmodule
